// File: rtl/prefix_adder_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// prefix_adder_pipe : elastic ready/valid Kogge-Stone adder/subtractor
// Revision 1.0
// ============================================================================
module prefix_adder_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int MID    = STAGES - 1;  // last rank that carries prefix state

  logic [STAGES:1] vld;
  logic [STAGES:1] rdy;
  logic [STAGES:1] up;

  logic [WIDTH-1:0] pr [1:MID];   // per-bit propagate, needed again for the sum
  logic [WIDTH-1:0] gg [1:MID];   // group generate
  logic [WIDTH-1:0] gp [1:MID];   // group propagate
  logic [MID:1]     ci;

  logic [WIDTH-1:0] nx_g [2:MID];
  logic [WIDTH-1:0] nx_p [2:MID];

  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] nxt_sum;

  assign bx = sub ? ~b : b;

  // A rank may load when empty or when its own beat moves on this cycle.
  always_comb begin
    rdy = '0;
    rdy[STAGES] = ~vld[STAGES] | out_ready;
    for (int k = STAGES - 1; k >= 1; k--) begin
      rdy[k] = ~vld[k] | rdy[k+1];
    end
  end

  assign up        = {vld[STAGES-1:1], in_valid};
  assign in_ready  = rdy[1];
  assign out_valid = vld[STAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld <= '0;
    end else if (flush) begin
      vld <= '0;
    end else begin
      for (int k = 1; k <= STAGES; k++) begin
        if (rdy[k]) begin
          vld[k] <= up[k];
        end
      end
    end
  end

  // One Kogge-Stone level per rank; ranks past the last level just copy.
  always_comb begin
    int d;
    for (int k = 2; k <= MID; k++) begin
      nx_g[k] = gg[k-1];
      nx_p[k] = gp[k-1];
      d = 1 << (k - 2);
      if ((k - 2) < LEVELS) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (i >= d) begin
            nx_g[k][i] = gg[k-1][i] | (gp[k-1][i] & gg[k-1][i-d]);
            nx_p[k][i] = gp[k-1][i] & gp[k-1][i-d];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rdy[1] & in_valid) begin
      pr[1] <= a ^ bx;
      gg[1] <= a & bx;
      gp[1] <= a ^ bx;
      ci[1] <= cin;
    end
    for (int k = 2; k <= MID; k++) begin
      if (rdy[k] & vld[k-1]) begin
        pr[k] <= pr[k-1];
        gg[k] <= nx_g[k];
        gp[k] <= nx_p[k];
        ci[k] <= ci[k-1];
      end
    end
  end

  // carry[i] is the carry into bit i; carry[WIDTH] is the carry out.
  always_comb begin
    carry    = '0;
    carry[0] = ci[MID];
    for (int i = 0; i < WIDTH; i++) begin
      carry[i+1] = gg[MID][i] | (gp[MID][i] & ci[MID]);
    end
  end

  assign nxt_sum = pr[MID] ^ carry[WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else if (rdy[STAGES] & vld[MID]) begin
      sum  <= nxt_sum;
      cout <= carry[WIDTH];
      ovf  <= carry[WIDTH] ^ carry[WIDTH-1];
      zero <= ~|nxt_sum;
    end
  end

endmodule
`default_nettype wire
